// File: rtl/alu_pkg.sv
// Shared types and helpers for the accumulator stage that sits behind the
// per-bit Logic slice array.
//   ACC_W      : datapath width the shift helper is built for
//   op_e       : 3-bit command encoding
//   state_e    : sequencer states
//   shift_step : one 1-bit step of SHL / SHR / ROL
package alu_pkg;

    localparam int ACC_W = 8;

    typedef enum logic [2:0] {
        OP_NOP   = 3'b000,
        OP_LOAD  = 3'b001,
        OP_LOGIC = 3'b010,
        OP_CLEAR = 3'b011,
        OP_SHL   = 3'b100,
        OP_SHR   = 3'b101,
        OP_ROL   = 3'b110,
        OP_INC   = 3'b111
    } op_e;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    // One serial step; non-shift op codes pass the value through unchanged.
    function automatic logic [ACC_W-1:0] shift_step(input logic [ACC_W-1:0] acc,
                                                    input op_e op);
        logic [ACC_W-1:0] res;
        res = acc;
        case (op)
            OP_SHL:  res = {acc[ACC_W-2:0], 1'b0};
            OP_SHR:  res = {1'b0, acc[ACC_W-1:1]};
            OP_ROL:  res = {acc[ACC_W-2:0], acc[ACC_W-1]};
            default: res = acc;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/alu_accumulator_if.sv
// Command / status bundle of the accumulator stage.
//   master : command source (drives op_valid, op_code, h_in, din, shamt)
//   slave  : the accumulator (drives op_ready, acc, zero, busy, done)
interface alu_accumulator_if #(
    parameter int WIDTH   = 8,
    parameter int SHAMT_W = $clog2(WIDTH)
);
    logic               op_valid;
    logic               op_ready;
    logic [2:0]         op_code;
    logic [WIDTH-1:0]   h_in;
    logic [WIDTH-1:0]   din;
    logic [SHAMT_W-1:0] shamt;
    logic [WIDTH-1:0]   acc;
    logic               zero;
    logic               busy;
    logic               done;

    modport master (
        output op_valid, op_code, h_in, din, shamt,
        input  op_ready, acc, zero, busy, done
    );

    modport slave (
        input  op_valid, op_code, h_in, din, shamt,
        output op_ready, acc, zero, busy, done
    );
endinterface

// File: rtl/alu_accumulator.sv
// Accumulator register stage of the logic unit. acc feeds the Ai inputs of
// the Logic slices; their H vector comes back on h_in. Single-cycle ops
// update acc on the accept edge; shifts of n>=2 bits run serially in SHIFT.
//   clk, rst_n : clock (rising edge) and asynchronous active-low reset
//   bus        : command handshake (op_valid/op_ready), operands, and
//                status outputs acc, zero, busy, done
module alu_accumulator
    import alu_pkg::*;
#(
    parameter int WIDTH   = ACC_W,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic                clk,
    input  logic                rst_n,
    alu_accumulator_if.slave    bus
);

    state_e             state_r, state_nxt_s;
    op_e                shop_r, shop_nxt_s;
    op_e                op_s;
    logic [SHAMT_W-1:0] cnt_r, cnt_nxt_s;
    logic [WIDTH-1:0]   acc_r, acc_nxt_s;
    logic               done_r, done_nxt_s;

    assign op_s = op_e'(bus.op_code);

    // Sequencer and datapath mux: accept in IDLE, one serial step per edge in SHIFT.
    always_comb begin
        state_nxt_s = state_r;
        shop_nxt_s  = shop_r;
        cnt_nxt_s   = cnt_r;
        acc_nxt_s   = acc_r;
        done_nxt_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.op_valid) begin
                    done_nxt_s = 1'b1;
                    case (op_s)
                        OP_NOP:   acc_nxt_s = acc_r;
                        OP_LOAD:  acc_nxt_s = bus.din;
                        OP_LOGIC: acc_nxt_s = bus.h_in;
                        OP_CLEAR: acc_nxt_s = {WIDTH{1'b0}};
                        OP_INC:   acc_nxt_s = acc_r + WIDTH'(1);
                        OP_SHL, OP_SHR, OP_ROL: begin
                            if (bus.shamt == {SHAMT_W{1'b0}}) begin
                                acc_nxt_s = acc_r;
                            end else begin
                                // Accept edge already performs the first step.
                                acc_nxt_s = shift_step(acc_r, op_s);
                                if (bus.shamt == SHAMT_W'(1)) begin
                                    done_nxt_s = 1'b1;
                                end else begin
                                    done_nxt_s  = 1'b0;
                                    state_nxt_s = ST_SHIFT;
                                    cnt_nxt_s   = bus.shamt - SHAMT_W'(1);
                                    shop_nxt_s  = op_s;
                                end
                            end
                        end
                        default:  acc_nxt_s = acc_r;
                    endcase
                end else begin
                    done_nxt_s = 1'b0;
                end
            end
            ST_SHIFT: begin
                acc_nxt_s = shift_step(acc_r, shop_r);
                cnt_nxt_s = cnt_r - SHAMT_W'(1);
                if (cnt_r == SHAMT_W'(1)) begin
                    state_nxt_s = ST_IDLE;
                    done_nxt_s  = 1'b1;
                end else begin
                    state_nxt_s = ST_SHIFT;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = {SHAMT_W{1'b0}};
            end
        endcase
    end

    // State, counter, accumulator and done registers; reset aborts any shift.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            shop_r  <= OP_NOP;
            cnt_r   <= {SHAMT_W{1'b0}};
            acc_r   <= {WIDTH{1'b0}};
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            shop_r  <= shop_nxt_s;
            cnt_r   <= cnt_nxt_s;
            acc_r   <= acc_nxt_s;
            done_r  <= done_nxt_s;
        end
    end

    // Status depends only on registered state, so ready never follows valid.
    assign bus.acc      = acc_r;
    assign bus.zero     = (acc_r == {WIDTH{1'b0}});
    assign bus.op_ready = (state_r == ST_IDLE);
    assign bus.busy     = (state_r == ST_SHIFT);
    assign bus.done     = done_r;

endmodule

// File: tb/tb_alu_accumulator.sv
// Directed bench for alu_accumulator with hand-computed expected values.
module tb_alu_accumulator;
    import alu_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    alu_accumulator_if #(.WIDTH(8), .SHAMT_W(3)) bus ();

    alu_accumulator #(.WIDTH(8), .SHAMT_W(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Checks acc, done, busy, op_ready, zero in one go.
    task automatic chk_all(input string tag, input logic [7:0] a, input logic d,
                           input logic b, input logic r, input logic z);
        chk({tag, ".acc"},   bus.acc, a);
        chk({tag, ".done"},  {7'd0, bus.done}, {7'd0, d});
        chk({tag, ".busy"},  {7'd0, bus.busy}, {7'd0, b});
        chk({tag, ".ready"}, {7'd0, bus.op_ready}, {7'd0, r});
        chk({tag, ".zero"},  {7'd0, bus.zero}, {7'd0, z});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one command for a single edge, then drops op_valid.
    task automatic issue(input op_e op, input logic [7:0] d, input logic [7:0] h,
                         input logic [2:0] sa);
        bus.op_valid = 1'b1;
        bus.op_code  = op;
        bus.din      = d;
        bus.h_in     = h;
        bus.shamt    = sa;
        tick();
        bus.op_valid = 1'b0;
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        rst_n        = 1'b0;
        bus.op_valid = 1'b0;
        bus.op_code  = 3'b000;
        bus.din      = 8'h00;
        bus.h_in     = 8'h00;
        bus.shamt    = 3'd0;
        tick();
        // Command offered during reset must be ignored.
        bus.op_valid = 1'b1;
        bus.op_code  = OP_LOAD;
        bus.din      = 8'h55;
        tick();
        bus.op_valid = 1'b0;
        chk_all("reset", 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
        rst_n = 1'b1;
        tick();

        // 1: LOAD
        issue(OP_LOAD, 8'hA5, 8'h00, 3'd0);
        chk_all("load", 8'hA5, 1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        chk("load.done_clr", {7'd0, bus.done}, 8'h00);

        // 2: LOGIC then CLEAR back-to-back
        issue(OP_LOGIC, 8'h00, 8'h0F, 3'd0);
        chk_all("logic", 8'h0F, 1'b1, 1'b0, 1'b1, 1'b0);
        issue(OP_CLEAR, 8'h00, 8'h00, 3'd0);
        chk_all("clear", 8'h00, 1'b1, 1'b0, 1'b1, 1'b1);

        // 3: ROL by 3 from 81, with op_valid held high during SHIFT
        issue(OP_LOAD, 8'h81, 8'h00, 3'd0);
        chk("rol.pre", bus.acc, 8'h81);
        issue(OP_ROL, 8'h00, 8'h00, 3'd3);
        bus.op_valid = 1'b1;
        bus.op_code  = OP_LOAD;
        bus.din      = 8'hFF;
        chk_all("rol.s1", 8'h03, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        chk_all("rol.s2", 8'h06, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        bus.op_valid = 1'b0;
        chk_all("rol.s3", 8'h0C, 1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        chk_all("rol.after", 8'h0C, 1'b0, 1'b0, 1'b1, 1'b0);

        // 4: SHR by 0, SHL by 1, SHR by 2
        issue(OP_LOAD, 8'hF0, 8'h00, 3'd0);
        issue(OP_SHR, 8'h00, 8'h00, 3'd0);
        chk_all("shr0", 8'hF0, 1'b1, 1'b0, 1'b1, 1'b0);
        issue(OP_SHL, 8'h00, 8'h00, 3'd1);
        chk_all("shl1", 8'hE0, 1'b1, 1'b0, 1'b1, 1'b0);
        issue(OP_SHR, 8'h00, 8'h00, 3'd2);
        chk_all("shr2.s1", 8'h70, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        chk_all("shr2.s2", 8'h38, 1'b1, 1'b0, 1'b1, 1'b0);

        // 5: INC wrap, back-to-back LOAD, plain INC
        issue(OP_LOAD, 8'hFF, 8'h00, 3'd0);
        issue(OP_INC, 8'h00, 8'h00, 3'd0);
        chk_all("inc.wrap", 8'h00, 1'b1, 1'b0, 1'b1, 1'b1);
        issue(OP_LOAD, 8'h01, 8'h00, 3'd0);
        chk_all("b2b.load", 8'h01, 1'b1, 1'b0, 1'b1, 1'b0);
        issue(OP_NOP, 8'hEE, 8'hEE, 3'd0);
        chk_all("nop", 8'h01, 1'b1, 1'b0, 1'b1, 1'b0);
        issue(OP_INC, 8'h00, 8'h00, 3'd0);
        chk("inc", bus.acc, 8'h02);

        // 6: SHL by 7 from 01, reset after three steps
        issue(OP_LOAD, 8'h01, 8'h00, 3'd0);
        issue(OP_SHL, 8'h00, 8'h00, 3'd7);
        chk("shl7.s1", bus.acc, 8'h02);
        tick();
        chk("shl7.s2", bus.acc, 8'h04);
        tick();
        chk_all("shl7.s3", 8'h08, 1'b0, 1'b1, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        chk_all("abort", 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        rst_n = 1'b1;
        tick();
        chk_all("post_rst", 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
        issue(OP_LOAD, 8'h3C, 8'h00, 3'd0);
        chk_all("post_rst.load", 8'h3C, 1'b1, 1'b0, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_accumulator.md
Name: alu_accumulator

Overview:
- Accumulator register stage directly downstream of the per-bit Logic slice array (Ai, Bi, S1, S0 -> H).
- Captures the WIDTH-bit H vector, or other operations, into the accumulator.
- acc is fed back to the Ai inputs of the slices; Bi comes from the operand bus.
- Adds multi-cycle serial shift/rotate sequencing and a valid/ready command handshake, completing the logic-unit datapath.

Parameters:
WIDTH, 8, accumulator and datapath width in bits
SHAMT_W, $clog2(WIDTH), width of the shift-amount field

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
op_valid  in  1  command valid
op_ready  out  1  block can accept a command (high only in IDLE)
op_code  in  3  operation select, encodings below
h_in  in  WIDTH  H outputs of the Logic slice array, bit i from slice i
din  in  WIDTH  load operand
shamt  in  SHAMT_W  shift/rotate amount
acc  out  WIDTH  accumulator value; drives Ai of the Logic slices
zero  out  1  acc == 0, combinational from registered acc
busy  out  1  multi-cycle shift in progress
done  out  1  one-cycle pulse: the command just completed

Behaviour:
- Reset (asynchronous, rst_n low): acc=0, state=IDLE, counter=0, done=0, busy=0, zero=1, op_ready=1. Commands are ignored while rst_n is low.
- Reset mid-shift aborts the shift immediately: acc=0, no done pulse.
- Accept: on a rising edge with op_valid && op_ready. op_code, h_in, din and shamt are sampled on that edge only. No command is accepted while not ready.
- Op codes:
  - 000 NOP: acc unchanged.
  - 001 LOAD: acc<=din.
  - 010 LOGIC: acc<=h_in.
  - 011 CLEAR: acc<=0.
  - 100 SHL: shift left, 0 in at the LSB.
  - 101 SHR: logical shift right, 0 in at the MSB.
  - 110 ROL: rotate left, MSB wraps to the LSB.
  - 111 INC: acc<=acc+1, modulo 2^WIDTH, so all-ones wraps to 0.
- Single-cycle ops (NOP, LOAD, LOGIC, CLEAR, INC, and any shift with shamt=0):
  - acc updates on the accept edge.
  - done=1 for exactly the following cycle.
  - State stays IDLE, so op_ready stays 1 and back-to-back commands are allowed every cycle.
- Shift ops with shamt=n>0:
  - The accept edge performs the first 1-bit step and loads counter=n-1.
  - If n=1: stay in IDLE; done is high the next cycle.
  - Else go to SHIFT: busy=1, op_ready=0, one 1-bit step per edge, counter decrements.
  - The edge where counter==1 performs the last step and returns to IDLE.
  - done is high in the cycle after that edge, together with op_ready=1 and busy=0.
  - Total: n edges, n acc updates; acc shows each intermediate value.
- done is registered: set on the edge that performs the final update, cleared on the next edge unless another completion occurs.
- States: IDLE -> SHIFT (shift accepted with shamt>=2); SHIFT -> SHIFT (counter>1); SHIFT -> IDLE (counter==1). There is no other transition.
- zero always reflects the current acc, including intermediate shift values.
- No ready-to-valid combinational path: op_ready depends only on state.

Decomposition:
- Package alu_pkg holds:
  - op_e enum, 3-bit: OP_NOP, OP_LOAD, OP_LOGIC, OP_CLEAR, OP_SHL, OP_SHR, OP_ROL, OP_INC.
  - state_e enum: ST_IDLE, ST_SHIFT.
  - Pure function shift_step(acc, op) returning the 1-bit shifted/rotated value.
- No sub-module. The FSM, counter and datapath mux stay in alu_accumulator.
- The Logic slices are instantiated alongside it at the next level up, not inside it.

Test Plan:
1. Reset then LOAD din=8'hA5 -> next cycle acc=8'hA5, done=1 for one cycle, zero=0, op_ready stays 1.
2. acc=8'hA5, LOGIC with h_in=8'h0F -> acc=8'h0F, done pulse. Then CLEAR -> acc=0, zero=1.
3. acc=8'h81, ROL shamt=3 -> acc steps 8'h03, 8'h06, 8'h0C over 3 edges; busy=1 and op_ready=0 for 2 cycles; done once with acc=8'h0C. op_valid held high during SHIFT is not accepted.
4. acc=8'hF0, SHR shamt=0 -> acc unchanged 8'hF0, done pulse next cycle, no busy. Then SHL shamt=1 -> acc=8'hE0, single-cycle done.
5. acc=8'hFF, INC -> acc=8'h00, zero=1, done pulse. Back-to-back LOAD 8'h01 the next cycle is accepted -> acc=8'h01.
6. SHL shamt=7 from acc=8'h01, assert rst_n=0 after 3 steps (acc=8'h08) -> acc=0 immediately, state IDLE, no done. After release op_ready=1.
